fetch_decode_seq: RTL and testbench

Instruction fetch, timing-sequence and opcode-decode front end for the 8-bit CPU. It drives the memory address from PC, assembles the 16-bit instruction from two byte reads, and owns the PC and T0–T7 sequence counter. It exports `IR_out`, `T_out`, one-hot T and one-hot opcode strobes (AND…BNE) to the execute datapath directly downstream. It accepts completion and branch requests back from that datapath.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/fetch_decode_seq_seq_counter.sv | 68 ++++++
 rtl/fetch_decode_seq.sv | 125 ++++++++++++
 tb/tb_fetch_decode_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU front end.
// Holds the sequence-counter width, the named T states, the instruction
// register field positions, the opcode enumeration and a one-hot opcode
// helper used by the decode logic.
package cpu_pkg;

  // Sequence counter width and the named T states
  localparam int T_W = 3;
  localparam logic [T_W-1:0] T_FETCH_LO = 3'd0;
  localparam logic [T_W-1:0] T_FETCH_HI = 3'd1;
  localparam logic [T_W-1:0] T_EXEC     = 3'd2;
  localparam logic [T_W-1:0] T_STEP     = 3'd1;

  // Instruction register layout: opcode on top, register and address below
  localparam int IR_W    = 16;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 8;
  localparam int ADDR_HI = 7;
  localparam int ADDR_LO = 0;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,  OP_OR  = 4'd1,  OP_XOR = 4'd2,  OP_NOT = 4'd3,
    OP_ADD = 4'd4,  OP_SUB = 4'd5,  OP_INC = 4'd6,  OP_DEC = 4'd7,
    OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_LD  = 4'd10, OP_ST  = 4'd11,
    OP_MOV = 4'd12, OP_JMP = 4'd13, OP_BEQ = 4'd14, OP_BNE = 4'd15
  } opcode_e;

  // One-hot strobe for a 4-bit opcode
  function automatic logic [15:0] op_onehot(input logic [3:0] opc);
    op_onehot = 16'h0001 << opc;
  endfunction

endpackage

// File: rtl/fetch_decode_seq_seq_counter.sv
// seq_counter: T0..T7 instruction timing counter.
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   stall        - hold T for this cycle
//   done         - execute stage finished; return to T0 (execute phase only)
//   t            - registered sequence count
//   t_onehot     - combinational one-hot decode of t
//   overrun      - registered one-cycle pulse when T_MAX wraps without done
module seq_counter
  import cpu_pkg::*;
#(
  parameter int T_MAX = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall,
  input  logic           done,
  output logic [T_W-1:0] t,
  output logic [7:0]     t_onehot,
  output logic           overrun
);

  localparam logic [T_W-1:0] T_LAST = T_W'(T_MAX);

  logic [T_W-1:0] t_r;
  logic [T_W-1:0] t_next_s;
  logic           ovr_r;
  logic           ovr_next_s;

  // Next T: fetch states always advance, execute states advance until done or wrap
  always_comb begin
    t_next_s   = t_r;
    ovr_next_s = 1'b0;
    if (stall) begin
      t_next_s = t_r;
    end else if (t_r < T_EXEC) begin
      t_next_s = t_r + T_STEP;
    end else if (done) begin
      t_next_s = T_FETCH_LO;
    end else if (t_r == T_LAST) begin
      t_next_s   = T_FETCH_LO;
      ovr_next_s = 1'b1;
    end else begin
      t_next_s = t_r + T_STEP;
    end
  end

  // Counter and overrun pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_r   <= T_FETCH_LO;
      ovr_r <= 1'b0;
    end else begin
      t_r   <= t_next_s;
      ovr_r <= ovr_next_s;
    end
  end

  // One-hot decode of the current T
  always_comb begin
    t_onehot      = 8'h00;
    t_onehot[t_r] = 1'b1;
  end

  assign t       = t_r;
  assign overrun = ovr_r;

endmodule

// File: rtl/fetch_decode_seq.sv
// fetch_decode_seq: instruction fetch, T sequencing and opcode decode.
// Ports:
//   Clock, Reset         - rising-edge clock, asynchronous active-low reset
//   Stall                - freeze PC, IR, T and Op_out for the cycle
//   Mem_Data             - combinational read data at Mem_Addr
//   Done                 - execute finished (honoured only in T >= 2)
//   Branch_Load/Addr     - load PC with target (honoured only in T >= 2)
//   Mem_Addr, ARF_PC     - current PC
//   Mem_Rd               - read strobe in T0/T1 when not stalled
//   IR_out               - instruction register {high byte, low byte}
//   T_out, T0_out..T7_out- sequence count and its one-hot decode
//   Op_out               - registered one-hot opcode, zero during fetch
//   Overrun              - one-cycle pulse when T wraps without Done
module fetch_decode_seq
  import cpu_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter int         T_MAX    = 7
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Stall,
  input  logic [7:0]      Mem_Data,
  input  logic            Done,
  input  logic            Branch_Load,
  input  logic [7:0]      Branch_Addr,
  output logic [7:0]      Mem_Addr,
  output logic            Mem_Rd,
  output logic [7:0]      ARF_PC,
  output logic [IR_W-1:0] IR_out,
  output logic [T_W-1:0]  T_out,
  output logic            T0_out,
  output logic            T1_out,
  output logic            T2_out,
  output logic            T3_out,
  output logic            T4_out,
  output logic            T5_out,
  output logic            T6_out,
  output logic            T7_out,
  output logic [15:0]     Op_out,
  output logic            Overrun
);

  localparam logic [T_W-1:0] T_LAST = T_W'(T_MAX);

  logic [7:0]      pc_r;
  logic [7:0]      pc_next_s;
  logic [IR_W-1:0] ir_r;
  logic [IR_W-1:0] ir_next_s;
  logic [15:0]     op_r;
  logic [15:0]     op_next_s;
  logic [T_W-1:0]  t_s;
  logic [7:0]      t_oh_s;
  logic            ovr_s;

  seq_counter #(.T_MAX(T_MAX)) u_seq (
    .clk      (Clock),
    .rst_n    (Reset),
    .stall    (Stall),
    .done     (Done),
    .t        (t_s),
    .t_onehot (t_oh_s),
    .overrun  (ovr_s)
  );

  // Next PC / IR / opcode strobe from the current T state
  always_comb begin
    pc_next_s = pc_r;
    ir_next_s = ir_r;
    op_next_s = op_r;
    if (Stall) begin
      pc_next_s = pc_r;
    end else begin
      case (t_s)
        T_FETCH_LO: begin
          ir_next_s[7:0] = Mem_Data;
          pc_next_s      = pc_r + 8'd1;
          op_next_s      = 16'h0000;
        end
        T_FETCH_HI: begin
          // Opcode arrives with the high byte, so the strobe is ready when T enters 2
          ir_next_s[15:8] = Mem_Data;
          pc_next_s       = pc_r + 8'd1;
          op_next_s       = op_onehot(Mem_Data[OPC_HI-8:OPC_LO-8]);
        end
        default: begin
          if (Branch_Load) begin
            pc_next_s = Branch_Addr;
          end else begin
            pc_next_s = pc_r;
          end
          // Clear the strobe on the edge T returns to T0
          if (Done || (t_s == T_LAST)) begin
            op_next_s = 16'h0000;
          end else begin
            op_next_s = op_r;
          end
        end
      endcase
    end
  end

  // PC, IR and opcode strobe registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_r <= PC_RESET;
      ir_r <= 16'h0000;
      op_r <= 16'h0000;
    end else begin
      pc_r <= pc_next_s;
      ir_r <= ir_next_s;
      op_r <= op_next_s;
    end
  end

  assign Mem_Addr = pc_r;
  assign ARF_PC   = pc_r;
  assign Mem_Rd   = (t_s < T_EXEC) && !Stall;
  assign IR_out   = ir_r;
  assign T_out    = t_s;
  assign Op_out   = op_r;
  assign Overrun  = ovr_s;
  assign {T7_out, T6_out, T5_out, T4_out, T3_out, T2_out, T1_out, T0_out} = t_oh_s;

endmodule

// File: tb/tb_fetch_decode_seq.sv
// Self-checking bench for fetch_decode_seq: directed scenarios followed by
// randomized control inputs, all compared against a behavioural model.
module tb_fetch_decode_seq;

  localparam int TMAX = 7;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic [7:0]  Mem_Data;
  logic        Done = 1'b0;
  logic        Branch_Load = 1'b0;
  logic [7:0]  Branch_Addr = 8'h00;
  logic [7:0]  Mem_Addr;
  logic        Mem_Rd;
  logic [7:0]  ARF_PC;
  logic [15:0] IR_out;
  logic [2:0]  T_out;
  logic        T0_out, T1_out, T2_out, T3_out, T4_out, T5_out, T6_out, T7_out;
  logic [15:0] Op_out;
  logic        Overrun;

  logic [7:0]  mem [256];
  assign Mem_Data = mem[Mem_Addr];

  fetch_decode_seq #(.PC_RESET(8'h00), .T_MAX(TMAX)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Mem_Data(Mem_Data),
    .Done(Done), .Branch_Load(Branch_Load), .Branch_Addr(Branch_Addr),
    .Mem_Addr(Mem_Addr), .Mem_Rd(Mem_Rd), .ARF_PC(ARF_PC), .IR_out(IR_out),
    .T_out(T_out), .T0_out(T0_out), .T1_out(T1_out), .T2_out(T2_out),
    .T3_out(T3_out), .T4_out(T4_out), .T5_out(T5_out), .T6_out(T6_out),
    .T7_out(T7_out), .Op_out(Op_out), .Overrun(Overrun)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Reference state
  int         m_pc;
  int         m_t;
  logic [15:0] m_ir;
  logic        m_ov;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_t = 0; m_ir = 16'h0000; m_ov = 1'b0;
  endtask

  // One clock of the reference: fetch two bytes, then count execute cycles
  task automatic model_step(input logic st, input logic dn, input logic bl, input logic [7:0] ba);
    m_ov = 1'b0;
    if (!st) begin
      if (m_t == 0) begin
        m_ir[7:0] = mem[m_pc]; m_pc = (m_pc + 1) % 256; m_t = 1;
      end else if (m_t == 1) begin
        m_ir[15:8] = mem[m_pc]; m_pc = (m_pc + 1) % 256; m_t = 2;
      end else begin
        if (bl) m_pc = ba;
        if (dn) m_t = 0;
        else if (m_t == TMAX) begin m_t = 0; m_ov = 1'b1; end
        else m_t = m_t + 1;
      end
    end
  endtask

  task automatic check_all();
    logic [15:0] exp_op;
    exp_op = (m_t >= 2) ? (16'h0001 << m_ir[15:12]) : 16'h0000;
    chk("t", T_out, m_t);
    chk("t_onehot", {T7_out, T6_out, T5_out, T4_out, T3_out, T2_out, T1_out, T0_out}, 32'h1 << m_t);
    chk("pc", ARF_PC, m_pc);
    chk("mem_addr", Mem_Addr, m_pc);
    chk("ir", IR_out, m_ir);
    chk("op", Op_out, exp_op);
    chk("overrun", Overrun, m_ov);
  endtask

  // Drive inputs just after a falling edge, clock once, check after the next falling edge
  task automatic cycle(input logic st, input logic dn, input logic bl, input logic [7:0] ba);
    Stall = st; Done = dn; Branch_Load = bl; Branch_Addr = ba;
    #1;
    chk("mem_rd", Mem_Rd, (m_t < 2) && !st);
    @(posedge Clock);
    model_step(st, dn, bl, ba);
    @(negedge Clock);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h34; mem[8'h01] = 8'h12;
    mem[8'h02] = 8'h00; mem[8'h03] = 8'hF0;
    mem[8'h04] = 8'h77; mem[8'h05] = 8'h21;
    mem[8'h40] = 8'h00; mem[8'h41] = 8'h50;
    mem[8'hFE] = 8'hA5; mem[8'hFF] = 8'h3C;

    // Reset state
    model_reset();
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    #1;
    check_all();

    // Test 1: first fetch, OR opcode, Done in T2
    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    chk("t1_ir", IR_out, 16'h1234);
    chk("t1_op", Op_out, 16'h0002);
    chk("t1_pc", ARF_PC, 8'h02);
    cycle(0, 1, 0, 8'h00);
    chk("t1_t0", T_out, 3'd0);

    // Test 2: BNE, Done in T3
    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    chk("t2_op", Op_out, 16'h8000);
    cycle(0, 0, 0, 8'h00);
    chk("t2_t3", T_out, 3'd3);
    cycle(0, 1, 0, 8'h00);
    chk("t2_ir", IR_out, 16'hF000);
    chk("t2_pc", ARF_PC, 8'h04);

    // Test 3: stall in T1 with lost requests, branch in T1 ignored, branch+Done in T2
    cycle(0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 8'h99);
    chk("t3_stall_pc", ARF_PC, 8'h05);
    chk("t3_stall_t", T_out, 3'd1);
    cycle(0, 1, 1, 8'h99);
    chk("t3_bl_t1_pc", ARF_PC, 8'h06);
    chk("t3_ir", IR_out, 16'h2177);
    cycle(0, 1, 1, 8'h40);
    chk("t3_branch", Mem_Addr, 8'h40);

    // Test 4: overrun without Done
    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 8'h00);
    chk("t4_ovr_hi", Overrun, 1'b1);
    chk("t4_wrap_t", T_out, 3'd0);
    cycle(0, 0, 0, 8'h00);
    chk("t4_ovr_lo", Overrun, 1'b0);
    chk("t4_pc", ARF_PC, 8'h43);

    // Test 5: PC wrap through FE/FF
    cycle(0, 0, 0, 8'h00);
    cycle(0, 1, 1, 8'hFE);
    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    chk("t5_ir", IR_out, 16'h3CA5);
    chk("t5_pc", ARF_PC, 8'h00);
    cycle(0, 1, 0, 8'h00);

    // Asynchronous reset in the middle of T1
    cycle(0, 0, 0, 8'h00);
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_ir", IR_out, 16'h0000);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check_all();

    // Randomized phase
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 30),
            1'($urandom_range(0, 99) < 20), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
